// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: valid/ready handshake bundle for the BCD-to-binary converter
//   in_valid/in_ready/bcd_in    : input word handshake (producer -> converter)
//   out_valid/out_ready/bin_out/bcd_err : result handshake (converter -> consumer)
interface bcd2bin_seq_if #(parameter int DIGITS = 3, parameter int BIN_W = 10);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  bcd_err;
  modport master (output in_valid, bcd_in, out_ready, input in_ready, out_valid, bin_out, bcd_err);
  modport slave  (input in_valid, bcd_in, out_ready, output in_ready, out_valid, bin_out, bcd_err);
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble, one bit per cycle)
//   clk_i  : clock, all state on posedge
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of bcd2bin_seq_if (input word handshake, result handshake, error flag)
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bcd2bin_seq_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  if ((2 ** BIN_W) <= (10 ** DIGITS) - 1) begin : g_bad_width
    $error("bcd2bin_seq: BIN_W too small for DIGITS");
  end
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t            state_q;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]  bin_q, bin_d, bin_out_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q, bad, last;
  logic [BW+BIN_W-1:0] sh;
  // one step: shift {bcd,bin} right, then pull every bcd nibble >= 8 back by 3
  always_comb begin
    sh = {bcd_q, bin_q} >> 1;
    bin_d = sh[BIN_W-1:0];
    bcd_d = sh[BW+BIN_W-1:BIN_W];
    for (int i = 0; i < DIGITS; i++)
      bcd_d[4*i +: 4] = sh[BIN_W+4*i +: 4] >= 4'd8 ? sh[BIN_W+4*i +: 4] - 4'd3 : sh[BIN_W+4*i +: 4];
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (bus.bcd_in[4*i +: 4] > 4'd9);
  end
  assign last          = cnt_q == CW'(BIN_W - 1);
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.bin_out   = bin_out_q;
  assign bus.bcd_err   = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          if (bad) begin
            bin_out_q <= '0;
            err_q     <= 1'b1;
            state_q   <= DONE;
          end else begin
            bcd_q   <= bus.bcd_in;
            bin_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            bin_out_q <= bin_d;
            err_q     <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // a legal word must be fully drained out of the bcd field by the last step
  always @(posedge clk_i)
    if (rst_ni && state_q == CONV && last) assert (bcd_d == '0);
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed, table-driven bench for bcd2bin_seq
module tb_bcd2bin_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bcd2bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus();
  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  // drive a word for exactly one accepting edge; returns #1 after that edge
  task automatic send(input logic [11:0] w);
    bus.bcd_in = w;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic [7:0] a, b;
    logic [8:0] sum;
    logic [11:0] w;
    vecs[0] = '{12'h123, 10'd123, 1'b0, 10};
    vecs[1] = '{12'h999, 10'd999, 1'b0, 10};
    vecs[2] = '{12'h000, 10'd0,   1'b0, 10};
    vecs[3] = '{12'h1A5, 10'd0,   1'b1, 0};
    vecs[4] = '{12'h007, 10'd7,   1'b0, 10};
    vecs[5] = '{12'h0F0, 10'd0,   1'b1, 0};
    bus.in_valid = 1'b0;
    bus.bcd_in = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset bin_out", bus.bin_out, 0);
    chk("reset bcd_err", bus.bcd_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("idle in_ready", bus.in_ready, 1);
      send(vecs[i].bcd);
      wait_valid(lat);
      chk("vec latency", lat, vecs[i].lat);
      chk("vec bin_out", bus.bin_out, vecs[i].bin);
      chk("vec bcd_err", bus.bcd_err, vecs[i].err);
      release_out();
      chk("vec out_valid dropped", bus.out_valid, 0);
    end
    // backpressure: result held stable, then output handshake wins over a new word
    send(12'h250);
    wait_valid(lat);
    chk("bp latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp out_valid", bus.out_valid, 1);
      chk("bp bin_out", bus.bin_out, 250);
      chk("bp in_ready", bus.in_ready, 0);
    end
    bus.bcd_in = 12'h555;
    bus.in_valid = 1'b1;
    release_out();
    bus.in_valid = 1'b0;
    chk("bp back to idle", bus.in_ready, 1);
    chk("bp out_valid low", bus.out_valid, 0);
    // input during CONV is ignored
    send(12'h321);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.bcd_in = 12'h555;
    bus.in_valid = 1'b1;
    chk("conv in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("ignore latency", lat + 4, 10);
    chk("ignore bin_out", bus.bin_out, 321);
    release_out();
    repeat (12) @(posedge clk);
    #1;
    chk("ignore no second result", bus.out_valid, 0);
    // reset in the fourth cycle of a conversion
    send(12'h888);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset in_ready", bus.in_ready, 1);
    chk("midreset bin_out", bus.bin_out, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(12'h042);
    wait_valid(lat);
    chk("post-reset latency", lat, 10);
    chk("post-reset bin_out", bus.bin_out, 42);
    chk("post-reset bcd_err", bus.bcd_err, 0);
    release_out();
    // round trip: adder sum -> decimal digits -> converter
    for (int s = 0; s < 256; s++) begin
      a = 8'($urandom_range(0, s));
      b = 8'(s - int'(a));
      sum = a + b;
      w = {4'(sum / 100), 4'((sum / 10) % 10), 4'(sum % 10)};
      send(w);
      wait_valid(lat);
      chk("roundtrip bin_out", bus.bin_out, 32'(sum));
      chk("roundtrip bcd_err", bus.bcd_err, 0);
      release_out();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
